// File: rtl/writeback_unit_if.sv
// Bundle of the write-back unit's result, scoreboard and register-file write signals.
// The master side drives results and hazard selects; the slave side is the unit itself.
interface writeback_unit_if #(
   parameter int unsigned REG_WIDTH      = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH     = 4
);
   localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

   logic                      alu_valid;
   logic [REG_ADDR_WIDTH-1:0] alu_rd;
   logic [REG_WIDTH-1:0]      alu_data;

   logic                      lsu_valid;
   logic                      lsu_ready;
   logic [REG_ADDR_WIDTH-1:0] lsu_rd;
   logic [REG_WIDTH-1:0]      lsu_data;

   logic                      pend_set;
   logic [REG_ADDR_WIDTH-1:0] pend_rd;
   logic [REG_ADDR_WIDTH-1:0] ra_sel;
   logic [REG_ADDR_WIDTH-1:0] rb_sel;
   logic                      hazard;

   logic                      rf_we;
   logic [REG_ADDR_WIDTH-1:0] rf_rd;
   logic [REG_WIDTH-1:0]      rf_data;
   logic [CNT_WIDTH-1:0]      fifo_count;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output pend_set, pend_rd, ra_sel, rb_sel,
      input  lsu_ready, hazard, rf_we, rf_rd, rf_data, fifo_count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  pend_set, pend_rd, ra_sel, rb_sel,
      output lsu_ready, hazard, rf_we, rf_rd, rf_data, fifo_count
   );
endinterface

// File: rtl/writeback_unit.sv
// Write-back stage: merges ALU and buffered late results into one registered
// register-file write per cycle and tracks pending late writes per register.
module writeback_unit #(
   parameter int unsigned REG_WIDTH      = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter bit          R0_IS_ZERO     = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   writeback_unit_if.slave bus
);
   localparam int unsigned REG_COUNT = 2 ** REG_ADDR_WIDTH;
   localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

   logic [REG_ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
   logic [REG_WIDTH-1:0]      data_mem [FIFO_DEPTH];

   logic [PTR_WIDTH-1:0]      wptr_q, wptr_d;
   logic [PTR_WIDTH-1:0]      rptr_q, rptr_d;
   logic [CNT_WIDTH-1:0]      count_q, count_d;
   logic [REG_COUNT-1:0]      busy_q, busy_d;

   logic                      rf_we_q, rf_we_d;
   logic [REG_ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
   logic [REG_WIDTH-1:0]      rf_data_q, rf_data_d;

   logic                      push, pop;
   logic [REG_ADDR_WIDTH-1:0] head_rd;
   logic [REG_WIDTH-1:0]      head_data;
   logic                      sel_valid;
   logic [REG_ADDR_WIDTH-1:0] sel_rd;
   logic [REG_WIDTH-1:0]      sel_data;
   logic                      sel_is_r0;

   // Readiness looks only at the registered count, so a pop never frees a slot same-cycle.
   assign bus.lsu_ready = rst_n & (count_q < FULL_CNT);

   assign push      = bus.lsu_valid & bus.lsu_ready;
   assign pop       = ~bus.alu_valid & (count_q != '0);
   assign head_rd   = rd_mem[rptr_q];
   assign head_data = data_mem[rptr_q];

   assign sel_valid = bus.alu_valid | pop;
   assign sel_rd    = bus.alu_valid ? bus.alu_rd : head_rd;
   assign sel_data  = bus.alu_valid ? bus.alu_data : head_data;
   assign sel_is_r0 = R0_IS_ZERO && (sel_rd == '0);

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      rf_we_d   = 1'b0;
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;

      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A write to r0 still consumes its source but leaves the port idle.
      if (sel_valid && !sel_is_r0) begin
         rf_we_d   = 1'b1;
         rf_rd_d   = sel_rd;
         rf_data_d = sel_data;
      end
   end

   // Clear before set so a same-cycle dispatch to the popped register stays pending.
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[head_rd] = 1'b0;
      end
      if (bus.pend_set) begin
         busy_d[bus.pend_rd] = 1'b1;
      end
      if (R0_IS_ZERO) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         busy_q    <= '0;
         rf_we_q   <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         rf_we_q   <= rf_we_d;
         rf_rd_q   <= rf_rd_d;
         rf_data_q <= rf_data_d;
      end
   end

   // Storage needs no reset: an entry is only read once the count says it was written.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wptr_q]   <= bus.lsu_rd;
         data_mem[wptr_q] <= bus.lsu_data;
      end
   end

   assign bus.hazard     = busy_q[bus.ra_sel] | busy_q[bus.rb_sel];
   assign bus.rf_we      = rf_we_q;
   assign bus.rf_rd      = rf_rd_q;
   assign bus.rf_data    = rf_data_q;
   assign bus.fifo_count = count_q;
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-back stage feeding the register file's single synchronous write port.
- Merges two result sources into one registered write per cycle:
  - single-cycle ALU results;
  - late load/multi-cycle results, which are buffered in a small FIFO.
- Keeps a per-register pending scoreboard so the issue stage can detect read-after-write hazards on registers with outstanding late writes.

Parameters:
- REG_WIDTH, 32, data width of a register.
- REG_ADDR_WIDTH, 5, register index width; REG_COUNT = 2**REG_ADDR_WIDTH.
- FIFO_DEPTH, 4, late-result buffer entries; power of two, >= 2.
- R0_IS_ZERO, 1, when 1, writes to r0 are suppressed and r0 is never marked pending.

Ports:
- Clk_i  in  1  clock; all state updates on rising edge.
- Rst_ni  in  1  synchronous active-low reset.
- Alu_Valid_i  in  1  ALU result valid this cycle; always accepted (no backpressure).
- Alu_Rd_i  in  REG_ADDR_WIDTH  ALU destination register.
- Alu_Data_i  in  REG_WIDTH  ALU result.
- Lsu_Valid_i  in  1  late result offered.
- Lsu_Ready_o  out  1  late result accepted when Lsu_Valid_i && Lsu_Ready_o.
- Lsu_Rd_i  in  REG_ADDR_WIDTH  late result destination.
- Lsu_Data_i  in  REG_WIDTH  late result data.
- Pend_Set_i  in  1  issue stage dispatched a late op; mark Pend_Rd_i pending.
- Pend_Rd_i  in  REG_ADDR_WIDTH  destination of the dispatched late op.
- Ra_Sel_i  in  REG_ADDR_WIDTH  issue-stage source A index for the hazard check.
- Rb_Sel_i  in  REG_ADDR_WIDTH  issue-stage source B index for the hazard check.
- Hazard_o  out  1  combinational: busy[Ra_Sel_i] | busy[Rb_Sel_i].
- Rf_We_o  out  1  registered write enable to the register file.
- Rf_Rd_o  out  REG_ADDR_WIDTH  registered write index.
- Rf_Data_o  out  REG_WIDTH  registered write data.
- Fifo_Count_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (Rst_ni low at a rising edge):
  - Rf_We_o=0, Rf_Rd_o=0, Rf_Data_o=0.
  - FIFO emptied (pointers and count = 0); all busy bits cleared.
  - Any in-flight FIFO contents are discarded.
  - Lsu_Ready_o=0 while Rst_ni is low.
- Lsu_Ready_o = (count < FIFO_DEPTH) when out of reset. It is 0 when full; a simultaneous pop does not re-enable push in the same cycle.
- Push: on an accepted handshake, {Lsu_Rd_i, Lsu_Data_i} is written at the write pointer. The pointer wraps modulo FIFO_DEPTH.
- Write-port arbitration, one write per cycle, in this priority:
  - Alu_Valid_i=1: capture the ALU result into the Rf_* registers. The FIFO is not popped.
  - else if count>0: pop the FIFO head into the Rf_* registers. The read pointer wraps modulo FIFO_DEPTH.
  - else: Rf_We_o<=0.
- Latency:
  - ALU result presented in cycle N -> Rf_We_o=1 in cycle N+1.
  - Late result accepted in cycle N -> earliest Rf_We_o in cycle N+2. There is no empty-FIFO bypass.
- Starvation: continuous Alu_Valid_i can starve the FIFO. This is acceptable; the issue stage guarantees gaps.
- Count update: count += push - pop. Simultaneous push and pop leaves the count unchanged. Count never exceeds FIFO_DEPTH.
- R0_IS_ZERO=1 and selected write has rd=0:
  - Rf_We_o<=0, but the FIFO entry is still consumed.
  - Rf_Rd_o/Rf_Data_o are don't-care and hold their previous value.
- Scoreboard (REG_COUNT busy bits):
  - Set: Pend_Set_i sets busy[Pend_Rd_i]. Ignored for index 0 when R0_IS_ZERO=1.
  - Clear: a FIFO pop clears busy[head rd]. A clear on a bit that is not set is harmless.
  - Same rd set and cleared in the same cycle: set wins (busy stays 1).
  - ALU writes never touch busy bits.
  - With R0_IS_ZERO=1, busy[0] reads as 0.
- Hazard_o is purely combinational from the current busy state. It does not include same-cycle Pend_Set_i.
- All Rf_* outputs are driven directly from flops.

Test Plan:
- Reset with Rst_ni=0 for 2 cycles, then release -> Rf_We_o=0, Fifo_Count_o=0, Hazard_o=0 for all selects; Lsu_Ready_o=0 during reset, 1 on the first cycle after release.
- ALU only: Alu_Valid_i=1, Rd=5, Data=0xDEADBEEF in cycle 10 -> Rf_We_o=1, Rf_Rd_o=5, Rf_Data_o=0xDEADBEEF in cycle 11, Rf_We_o=0 in cycle 12.
- Late path with scoreboard:
  - Pend_Set_i rd=7 in cycle 1 -> Hazard_o=1 with Ra_Sel_i=7 from cycle 2.
  - Lsu push rd=7, data=0x1234 in cycle 5 -> Rf_We_o with rd=7, data=0x1234 in cycle 7.
  - Hazard_o=0 from cycle 7 (busy bit cleared on the cycle-6 pop).
- Fill and arbitration:
  - Hold Alu_Valid_i=1 and push 4 LSU results (rd 1..4) -> Lsu_Ready_o=0 at count=4, ALU writes win every cycle.
  - Drop Alu_Valid_i -> rd 1,2,3,4 written in order on 4 consecutive cycles; Lsu_Ready_o=1 again once count=3.
- r0 and set/clear collision:
  - LSU result to rd=0 -> entry popped, Rf_We_o stays 0.
  - Pend_Set_i rd=9 in the same cycle a FIFO pop with rd=9 occurs -> busy[9] remains 1.
- Reset mid-operation: 3 entries queued and busy[3]=1, assert Rst_ni=0 for 1 cycle -> Fifo_Count_o=0, Hazard_o=0, and no queued entry is ever written.
